// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: data width, fetch FSM encoding, NOP and the
// fetch-to-IF/ID payload.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush clears valid, hold freezes everything,
// load captures a fetched instruction together with its PC and PC+4.
module if_id_reg
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            hold,
    input  logic            flush,
    input  fetch_pkt_t      pkt,
    output logic            valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    // Flush outranks hold, hold outranks load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            inst     <= '0;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load && !hold) begin
            valid    <= 1'b1;
            inst     <= pkt.inst;
            pc       <= pkt.pc;
            pc_plus4 <= pkt.pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and
// fills the IF/ID register. Optional counters enabled by FETCH_PERF_CNT_EN.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     IMEM_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] im_addr,
    output logic            im_en,
    input  logic [XLEN-1:0] im_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_stall,
`endif
    output logic            fetch_err
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic            err_nxt;
    logic            fire;
    logic            redir_take;
    logic            in_range;
    logic            if_load;
    logic            if_hold;
    logic            if_flush;
    fetch_pkt_t      pkt;

    assign im_addr  = {2'b00, pc[XLEN-1:2]};
    assign in_range = (32'(pc[XLEN-1:2]) < IMEM_DEPTH);
    assign pkt      = '{inst: im_inst, pc: pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            fetch_err <= err_nxt;
        end
    end

    // Next state, PC update and IF/ID controls; a redirect beats everything.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        err_nxt    = fetch_err;
        im_en      = 1'b0;
        fire       = 1'b0;
        redir_take = 1'b0;

        case (state)
            BOOT: begin
                state_nxt  = RUN;
                redir_take = redirect_valid;
            end
            RUN: begin
                im_en      = !id_valid || id_ready;
                redir_take = redirect_valid;
                if (!redirect_valid) begin
                    if (!in_range) begin
                        err_nxt   = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        fire = im_en;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = HALT;
            end
        endcase

        if (redir_take) begin
            if (redirect_pc[1:0] != 2'b00) begin
                err_nxt   = 1'b1;
                state_nxt = HALT;
            end else begin
                pc_nxt = redirect_pc;
            end
        end else if (fire) begin
            pc_nxt = pc + 32'd4;
        end

        // Decode taking the current entry without a refill empties the register.
        if_load  = fire;
        if_flush = redir_take || (id_ready && !fire);
        if_hold  = !if_flush && !if_load;
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (if_load),
        .hold     (if_hold),
        .flush    (if_flush),
        .pkt      (pkt),
        .valid    (id_valid),
        .inst     (id_inst),
        .pc       (id_pc),
        .pc_plus4 (id_pc_plus4)
    );

`ifdef FETCH_PERF_CNT_EN
    logic stall_c;

    assign stall_c = (state == RUN) && id_valid && !id_ready;

    // Saturating fetch and stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (fire && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall_c && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, range/drain and
// reset sequences, and a randomized run against a stream-level model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] im_addr;
    logic        im_en;
    logic [31:0] im_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    logic [31:0] mem [32];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .im_addr        (im_addr),
        .im_en          (im_en),
        .im_inst        (im_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
`endif
        .fetch_err      (fetch_err)
    );

    // Instruction memory: combinational read, zero when disabled.
    always_comb begin
        if (!im_en)                im_inst = 32'h0;
        else if (im_addr < 32'd32) im_inst = mem[im_addr[4:0]];
        else                       im_inst = 32'hBAD0_0000 ^ im_addr;
    end

    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic        err;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic check_id(input logic [31:0] epc, input string tag);
        logic [31:0] w;
        w = mem[epc[6:2]];
        chk({tag, " id_valid"}, 32'(id_valid), 32'd1);
        chk({tag, " id_pc"}, id_pc, epc);
        chk({tag, " id_inst"}, id_inst, w);
        chk({tag, " id_pc_plus4"}, id_pc_plus4, epc + 32'd4);
    endtask

    // Asserts reset, then releases it at a falling edge so the next rising edge is BOOT.
    task automatic do_reset();
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply_row(input vec_t r, input int idx);
        string tag;
        tag = $sformatf("row%0d", idx);
        id_ready       = r.ready;
        redirect_valid = r.rv;
        redirect_pc    = r.rpc;
        #1;
        chk({tag, " im_en"}, 32'(im_en), 32'(r.en));
        chk({tag, " im_addr"}, im_addr, r.addr);
        @(posedge clk);
        #1;
        chk({tag, " id_valid"}, 32'(id_valid), 32'(r.valid));
        chk({tag, " fetch_err"}, 32'(fetch_err), 32'(r.err));
        if (r.valid) check_id(r.pc, tag);
    endtask

    int          n_acc;
    int          since_redir;
    logic [31:0] exp_pc;
    logic        prev_stall;
    logic        prev_redir;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;

        //            ready rv   rpc        en   addr    valid pc         err
        vt[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'd0,  1'b0, 32'h0,  1'b0};
        vt[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'd0,  1'b1, 32'h0,  1'b0};
        vt[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'd1,  1'b1, 32'h4,  1'b0};
        vt[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'd2,  1'b1, 32'h8,  1'b0};
        vt[4]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'd3,  1'b1, 32'h8,  1'b0};
        vt[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'd3,  1'b1, 32'h8,  1'b0};
        vt[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'd3,  1'b1, 32'h8,  1'b0};
        vt[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'd3,  1'b1, 32'hC,  1'b0};
        vt[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'd4,  1'b1, 32'hC,  1'b0};
        vt[9]  = '{1'b0, 1'b1, 32'h40, 1'b0, 32'd4,  1'b0, 32'h0,  1'b0};
        vt[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'd16, 1'b1, 32'h40, 1'b0};
        vt[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'd17, 1'b1, 32'h44, 1'b0};
        vt[12] = '{1'b1, 1'b1, 32'h42, 1'b1, 32'd18, 1'b0, 32'h0,  1'b1};
        vt[13] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'd18, 1'b0, 32'h0,  1'b1};
        vt[14] = '{1'b0, 1'b1, 32'h10, 1'b0, 32'd18, 1'b0, 32'h0,  1'b1};

        // Reset values.
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst id_valid", 32'(id_valid), 32'd0);
        chk("rst id_inst", id_inst, 32'd0);
        chk("rst id_pc", id_pc, 32'd0);
        chk("rst id_pc_plus4", id_pc_plus4, 32'd0);
        chk("rst fetch_err", 32'(fetch_err), 32'd0);
        chk("rst im_en", 32'(im_en), 32'd0);
        chk("rst im_addr", im_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Boot, sequential fetch, stall, redirect under stall, misaligned halt.
        for (int i = 0; i < 15; i++) apply_row(vt[i], i);

        // Reset in the middle of HALT clears everything at once.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst fetch_err", 32'(fetch_err), 32'd0);
        chk("midrst id_valid", 32'(id_valid), 32'd0);
        chk("midrst im_en", 32'(im_en), 32'd0);
        chk("midrst im_addr", im_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) apply_row(vt[i], 100 + i);

        // Run to the end of memory; the last word drains after the halt.
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            id_ready = 1'b1;
            @(posedge clk);
            #1;
            if (c >= 1) check_id(32'((c - 1) * 4), $sformatf("seq%0d", c));
            chk("seq fetch_err", 32'(fetch_err), 32'd0);
        end
        id_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("range fetch_err", 32'(fetch_err), 32'd1);
        chk("range im_en", 32'(im_en), 32'd0);
        chk("range im_addr", im_addr, 32'd32);
        check_id(32'h7C, "range held");
        @(posedge clk);
        #1;
        check_id(32'h7C, "range held2");
        id_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("range drained", 32'(id_valid), 32'd0);
        chk("range err sticky", 32'(fetch_err), 32'd1);
        chk("range im_en off", 32'(im_en), 32'd0);

`ifdef FETCH_PERF_CNT_EN
        // Ten fetches then three stalled cycles.
        do_reset();
        id_ready = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        id_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("perf_fetched", perf_fetched, 32'd10);
        chk("perf_stall", perf_stall, 32'd3);
`endif

        // Random run: decode must see the sequential stream, restarted at each redirect target.
        do_reset();
        #1;
        exp_pc      = 32'h0;
        n_acc       = 0;
        since_redir = 0;
        prev_stall  = 1'b0;
        prev_redir  = 1'b0;
        prev_pc     = 32'h0;
        prev_inst   = 32'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (prev_redir) begin
                chk("rnd flush", 32'(id_valid), 32'd0);
            end else if (prev_stall) begin
                chk("rnd hold valid", 32'(id_valid), 32'd1);
                chk("rnd hold pc", id_pc, prev_pc);
                chk("rnd hold inst", id_inst, prev_inst);
            end
            chk("rnd fetch_err", 32'(fetch_err), 32'd0);

            rdy = ($urandom % 4) != 0;
            rv  = (since_redir >= 8) || (($urandom % 8) == 0);
            tgt = 32'($urandom_range(0, 15)) * 32'd4;
            id_ready       = rdy;
            redirect_valid = rv;
            redirect_pc    = tgt;

            if (rv) begin
                exp_pc      = tgt;
                since_redir = 0;
            end else begin
                since_redir++;
                if (id_valid && rdy) begin
                    chk("rnd acc pc", id_pc, exp_pc);
                    chk("rnd acc inst", id_inst, mem[exp_pc[6:2]]);
                    chk("rnd acc pc4", id_pc_plus4, exp_pc + 32'd4);
                    exp_pc = exp_pc + 32'd4;
                    n_acc++;
                end
            end
            prev_stall = id_valid && !rdy && !rv;
            prev_redir = rv;
            prev_pc    = id_pc;
            prev_inst  = id_inst;
            @(posedge clk);
            #1;
        end
        chk("rnd progress", 32'(n_acc >= 300), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage for the RV32I+M core, directly upstream of the instruction memory.
- Owns the PC and drives the memory's word address and enable.
- Captures the returned instruction into an IF/ID register that feeds decode through a valid/ready handshake.
- Handles decode back-pressure, branch/jump redirects with flush, and halts on illegal fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- IMEM_DEPTH, 32, number of 32-bit words in the instruction memory; word index >= IMEM_DEPTH is out of range.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- im_addr  out  32  word index to the instruction memory, {2'b00, pc[31:2]}.
- im_en  out  1  instruction-memory enable; the memory returns 0 when low.
- im_inst  in  32  instruction word, combinational from im_addr in the same cycle.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  byte target of the redirect.
- id_ready  in  1  decode can accept id_* this cycle.
- id_valid  out  1  id_* holds a valid instruction.
- id_inst  out  32  registered instruction.
- id_pc  out  32  byte PC of id_inst.
- id_pc_plus4  out  32  id_pc + 4 (mod 2^32).
- fetch_err  out  1  sticky; set on a misaligned redirect or out-of-range fetch.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT.
  - id_valid=0, id_inst=0, id_pc=0, id_pc_plus4=0, fetch_err=0.
  - im_en=0, im_addr={2'b00,RESET_PC[31:2]}.
  - Reset asserted mid-operation discards everything immediately.
- FSM states:
  - BOOT: im_en=0 for exactly one cycle, then go to RUN unconditionally.
  - RUN: normal fetch.
  - HALT: im_en=0, pc frozen. Exit only by reset.
- Fetch in RUN:
  - im_en = !id_valid | id_ready.
  - fire = im_en & !redirect_valid & in_range, where in_range = (pc[31:2] < IMEM_DEPTH).
  - On fire: id_inst<=im_inst, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
  - Throughput is one instruction per cycle while id_ready=1.
- Back-pressure:
  - If id_valid & !id_ready: all id_* hold stable, pc holds, im_en=0.
- Drain:
  - If id_ready & !fire: id_valid<=0.
- Redirect (highest priority, honoured in BOOT and RUN, ignored in HALT):
  - pc<=redirect_pc and id_valid<=0 (flush) in the same cycle, regardless of id_ready.
  - No fetch occurs in the redirect cycle.
  - Target instruction appears on id_* at the edge after the next; redirect at edge N gives id_valid=1 with id_pc=target after edge N+2.
  - A redirect in BOOT replaces pc; BOOT still lasts one cycle.
  - If redirect_pc[1:0] != 0: fetch_err<=1, state<=HALT, id_valid<=0, pc unchanged.
- Out-of-range:
  - In RUN with !in_range and no redirect: fetch_err<=1, state<=HALT.
  - An already-valid id_* still drains normally on id_ready.
- Wrap: pc+4 wraps modulo 2^32; the out-of-range check catches a wrapped PC when IMEM_DEPTH < 2^30.
- Simultaneous events: a redirect together with a stall means the redirect wins and decode's held instruction is dropped.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched (32) and perf_stall (32), both reset to 0.
  - perf_fetched increments on each fire.
  - perf_stall increments each RUN cycle with id_valid & !id_ready.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package rv32_pkg holds:
  - XLEN=32.
  - fetch FSM state encoding: BOOT=2'd0, RUN=2'd1, HALT=2'd2.
  - NOP constant 32'h0000_0013.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with hold/flush/load controls.
- PC logic and FSM stay in fetch_unit.

Test Plan:
- Reset release, id_ready=1: no fetch on cycle 0 (BOOT); then id_pc = 0, 4, 8, … one per cycle. im_addr = 0, 1, 2 and id_inst matches the memory word.
- Stall: hold id_ready=0 for 3 cycles with id_pc=8 valid. id_* stay stable and im_en=0; on release, the next id_pc is 12 with no skip or duplicate.
- Redirect: redirect_valid with redirect_pc=0x40 while a stall is in progress. id_valid=0 next cycle and id_pc=0x40 two edges later, even with id_ready=0 at the redirect.
- Misaligned: redirect_pc=0x42. fetch_err=1, HALT, id_valid=0, im_en=0 permanently; asserting rst_n=0 mid-HALT clears fetch_err and restarts at RESET_PC.
- Range: with IMEM_DEPTH=32, run sequentially to pc=0x7C. Word 31 is delivered; at pc=0x80 fetch_err=1, HALT, and the last valid instruction still drains.
- With FETCH_PERF_CNT_EN defined: 10 fetches and 3 stall cycles give perf_fetched=10 and perf_stall=3.
